// File: rtl/display_scanner.sv
// display_scanner
//   Time-multiplexed driver for a four-digit, common-anode seven-segment
//   display (stopwatch MM:SS). Latches the four BCD digits once per scan
//   frame, decodes them to active-low segment patterns, cycles the anodes,
//   and blinks the digit pair under adjustment while adjust mode is on.
//
//   Parameters
//     REFRESH_DIV  in_clock cycles each digit stays lit (>= 2)
//     BLINK_DIV    in_clock cycles per blink half-period (>= 2)
//
//   Ports
//     in_clock     board clock, rising edge
//     in_reset     asynchronous, active-high reset
//     in_minute1   minutes tens digit (BCD)
//     in_minute0   minutes units digit (BCD)
//     in_second1   seconds tens digit (BCD)
//     in_second0   seconds units digit (BCD)
//     in_adjust    adjust mode enable (synchronous to in_clock)
//     in_select    adjust target: 1 = seconds pair, 0 = minutes pair
//     out_an       anode enables, active-low, bit 0 = rightmost digit
//     out_seg      segments, active-low, bit 7 = dp (always off), 6:0 = g..a
module display_scanner #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic [3:0] in_minute1,
  input  logic [3:0] in_minute0,
  input  logic [3:0] in_second1,
  input  logic [3:0] in_second0,
  input  logic       in_adjust,
  input  logic       in_select,
  output logic [3:0] out_an,
  output logic [7:0] out_seg
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  // Scan slot; encoding equals the digit index (0 = rightmost digit).
  typedef enum logic [1:0] {
    SLOT_SEC0 = 2'd0,
    SLOT_SEC1 = 2'd1,
    SLOT_MIN0 = 2'd2,
    SLOT_MIN1 = 2'd3
  } slot_t;

  slot_t         r_slot;
  slot_t         w_slot_next;

  logic [RW-1:0] r_refresh;
  logic          w_tick;
  logic          w_frame_end;

  logic [3:0]    r_snap_minute1;
  logic [3:0]    r_snap_minute0;
  logic [3:0]    r_snap_second1;
  logic [3:0]    r_snap_second0;

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic          w_blink_wrap;

  logic [3:0]    w_digit;
  logic [3:0]    w_an_next;
  logic [7:0]    w_seg_next;
  logic [7:0]    w_seg_decoded;
  logic          w_selected_pair;

  // Refresh counter: one tick per slot period.
  assign w_tick      = (r_refresh == REFRESH_LAST);
  assign w_frame_end = w_tick && (r_slot == SLOT_MIN1);

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_refresh <= '0;
    end else if (w_tick) begin
      r_refresh <= '0;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  // Slot state register.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_slot <= SLOT_SEC0;
    end else begin
      r_slot <= w_slot_next;
    end
  end

  // Slot next-state logic.
  always_comb begin
    w_slot_next = r_slot;
    if (w_tick) begin
      case (r_slot)
        SLOT_SEC0: w_slot_next = SLOT_SEC1;
        SLOT_SEC1: w_slot_next = SLOT_MIN0;
        SLOT_MIN0: w_slot_next = SLOT_MIN1;
        SLOT_MIN1: w_slot_next = SLOT_SEC0;
        default:   w_slot_next = SLOT_SEC0;
      endcase
    end
  end

  // Snapshot taken only at the 3->0 wrap so a frame never mixes old and
  // new digits.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_snap_minute1 <= '0;
      r_snap_minute0 <= '0;
      r_snap_second1 <= '0;
      r_snap_second0 <= '0;
    end else if (w_frame_end) begin
      r_snap_minute1 <= in_minute1;
      r_snap_minute0 <= in_minute0;
      r_snap_second1 <= in_second1;
      r_snap_second0 <= in_second0;
    end
  end

  // Blink timer; held cleared whenever adjust mode is off.
  assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (!in_adjust) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_blink_wrap) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  // Output logic: digit mux, BCD decode, blanking.
  always_comb begin
    w_digit   = '0;
    w_an_next = '1;
    case (r_slot)
      SLOT_SEC0: begin w_digit = r_snap_second0; w_an_next = 4'b1110; end
      SLOT_SEC1: begin w_digit = r_snap_second1; w_an_next = 4'b1101; end
      SLOT_MIN0: begin w_digit = r_snap_minute0; w_an_next = 4'b1011; end
      SLOT_MIN1: begin w_digit = r_snap_minute1; w_an_next = 4'b0111; end
      default:   begin w_digit = '0;             w_an_next = '1;      end
    endcase

    case (w_digit)
      4'd0:    w_seg_decoded = 8'hC0;
      4'd1:    w_seg_decoded = 8'hF9;
      4'd2:    w_seg_decoded = 8'hA4;
      4'd3:    w_seg_decoded = 8'hB0;
      4'd4:    w_seg_decoded = 8'h99;
      4'd5:    w_seg_decoded = 8'h92;
      4'd6:    w_seg_decoded = 8'h82;
      4'd7:    w_seg_decoded = 8'hF8;
      4'd8:    w_seg_decoded = 8'h80;
      4'd9:    w_seg_decoded = 8'h90;
      default: w_seg_decoded = 8'hFF;
    endcase

    if (in_select) begin
      w_selected_pair = (r_slot == SLOT_SEC0) || (r_slot == SLOT_SEC1);
    end else begin
      w_selected_pair = (r_slot == SLOT_MIN0) || (r_slot == SLOT_MIN1);
    end

    w_seg_next = w_seg_decoded;
    if (r_blink_phase && w_selected_pair) begin
      w_an_next  = '1;
      w_seg_next = '1;
    end
  end

  // Registered outputs keep the display glitch-free.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      out_an  <= '1;
      out_seg <= '1;
    end else begin
      out_an  <= w_an_next;
      out_seg <= w_seg_next;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

  localparam int unsigned REFRESH_DIV = 4;
  localparam int unsigned BLINK_DIV   = 8;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [3:0] AN_S0  = 4'b1110;
  localparam logic [3:0] AN_S1  = 4'b1101;
  localparam logic [3:0] AN_M0  = 4'b1011;
  localparam logic [3:0] AN_M1  = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  logic       in_clock = 1'b0;
  logic       in_reset;
  logic [3:0] in_minute1;
  logic [3:0] in_minute0;
  logic [3:0] in_second1;
  logic [3:0] in_second0;
  logic       in_adjust;
  logic       in_select;
  logic [3:0] out_an;
  logic [7:0] out_seg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 in_clock = ~in_clock;

  display_scanner #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .in_clock  (in_clock),
    .in_reset  (in_reset),
    .in_minute1(in_minute1),
    .in_minute0(in_minute0),
    .in_second1(in_second1),
    .in_second0(in_second0),
    .in_adjust (in_adjust),
    .in_select (in_select),
    .out_an    (out_an),
    .out_seg   (out_seg)
  );

  task automatic step();
    @(posedge in_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] an, input logic [7:0] seg);
    n_checks++;
    assert ({out_an, out_seg} === {an, seg}) else begin
      n_fail++;
      $error("FAIL %s: got an=%b seg=%h, expected an=%b seg=%h",
             tag, out_an, out_seg, an, seg);
    end
  endtask

  task automatic chk_int(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_n(input string tag, input int n,
                          input logic [3:0] an, input logic [7:0] seg);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, an, seg);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    in_reset   = 1'b1;
    in_adjust  = 1'b0;
    in_select  = 1'b0;
    in_minute1 = 4'd1;
    in_minute0 = 4'd2;
    in_second1 = 4'd3;
    in_second0 = 4'd4;

    // Reset state
    step();
    step();
    chk("reset", AN_OFF, SEG_OFF);
    #3 in_reset = 1'b0;

    // Frame 1: snapshot still zero
    expect_n("f1_s0", 4, AN_S0, SEG_0);
    expect_n("f1_s1", 4, AN_S1, SEG_0);
    expect_n("f1_s2", 4, AN_M0, SEG_0);
    expect_n("f1_s3", 4, AN_M1, SEG_0);

    // Frame 2: 12:34; second0 changes mid-frame, must not show yet
    expect_n("f2_s0", 4, AN_S0, SEG_4);
    expect_n("f2_s1", 1, AN_S1, SEG_3);
    in_second0 = 4'd5;
    expect_n("f2_s1_after_chg", 3, AN_S1, SEG_3);
    expect_n("f2_s2", 4, AN_M0, SEG_2);
    expect_n("f2_s3", 4, AN_M1, SEG_1);

    // Frame 3: new second0 visible; invalid minute1 applied mid-frame
    expect_n("f3_s0", 1, AN_S0, SEG_5);
    in_minute1 = 4'hB;
    expect_n("f3_s0b", 3, AN_S0, SEG_5);
    expect_n("f3_s1", 4, AN_S1, SEG_3);
    expect_n("f3_s2", 4, AN_M0, SEG_2);
    expect_n("f3_s3", 4, AN_M1, SEG_1);

    // Frame 4: invalid BCD blanks segments with anode still on
    expect_n("f4_s0", 1, AN_S0, SEG_5);
    in_minute1 = 4'd1;
    expect_n("f4_s0b", 3, AN_S0, SEG_5);
    expect_n("f4_s1", 4, AN_S1, SEG_3);
    expect_n("f4_s2", 4, AN_M0, SEG_2);
    expect_n("f4_s3_invalid", 4, AN_M1, SEG_OFF);

    // Frame 5: enter adjust on seconds two cycles into slot 0
    expect_n("f5_s0", 2, AN_S0, SEG_5);
    in_adjust = 1'b1;
    in_select = 1'b1;
    expect_n("f5_s0b", 2, AN_S0, SEG_5);
    expect_n("f5_s1", 4, AN_S1, SEG_3);
    expect_n("f5_s2_min_lit", 4, AN_M0, SEG_2);
    expect_n("f5_s3_min_lit", 4, AN_M1, SEG_1);

    // Frame 6: blink phase 1 covers first half of slot 0
    expect_n("f6_s0_blank", 2, AN_OFF, SEG_OFF);
    expect_n("f6_s0_lit", 2, AN_S0, SEG_5);
    expect_n("f6_s1_lit", 4, AN_S1, SEG_3);
    expect_n("f6_s2_lit", 3, AN_M0, SEG_2);
    in_select = 1'b0;
    expect_n("f6_s2_sel_min_blank", 1, AN_OFF, SEG_OFF);
    expect_n("f6_s3_blank", 1, AN_OFF, SEG_OFF);
    in_adjust = 1'b0;
    expect_n("f6_s3_exit_blank", 1, AN_OFF, SEG_OFF);
    chk_int("blink_cnt_cleared", 32'(dut.r_blink_cnt), 32'd0);
    chk_int("blink_phase_cleared", 32'(dut.r_blink_phase), 32'd0);
    expect_n("f6_s3_relit", 2, AN_M1, SEG_1);

    // Frame 7: re-enter adjust, then reset during slot 2 with phase 1
    expect_n("f7_s0", 1, AN_S0, SEG_5);
    in_adjust = 1'b1;
    in_select = 1'b1;
    expect_n("f7_s0b", 3, AN_S0, SEG_5);
    expect_n("f7_s1", 4, AN_S1, SEG_3);
    expect_n("f7_s2", 2, AN_M0, SEG_2);
    chk_int("phase_before_reset", 32'(dut.r_blink_phase), 32'd1);
    #1 in_reset = 1'b1;
    #1 chk("async_reset", AN_OFF, SEG_OFF);
    chk_int("phase_after_reset", 32'(dut.r_blink_phase), 32'd0);
    in_adjust = 1'b0;
    step();
    step();
    chk("reset_hold", AN_OFF, SEG_OFF);
    #3 in_reset = 1'b0;

    // Restart at slot 0 with zeroed snapshot
    expect_n("post_rst_s0", 4, AN_S0, SEG_0);
    expect_n("post_rst_s1", 1, AN_S1, SEG_0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
